// File: rtl/gf_inverse.sv
// GF(2^8) multiplicative inverse, computed as x^254 by square-and-multiply.
// A byte is taken in IDLE and worked on for seven CALC cycles.
// The result is then presented in DONE until downstream takes it.
// 0x00 maps to 0x00 without any special case, because 0^254 = 0.
module gf_inverse #(
  parameter logic [7:0] REDUCE_POLY = 8'h1B
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state_q;
  logic [7:0] acc_q;
  logic [7:0] sq_q;
  logic [2:0] cnt_q;
  logic       out_valid_q;
  logic [7:0] out_data_q;

  logic [7:0] acc_d;
  logic [7:0] sq_d;
  logic [7:0] sq_init;

  // Shift-and-add multiply.
  // The shifted operand is reduced each time its top bit falls off, so every
  // intermediate value stays 8 bits wide.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ REDUCE_POLY) : (aa << 1);
    end
    return p;
  endfunction

  // Product terms for one CALC step. Both use the old register values.
  // After step k, acc holds x^(2+4+...+2^(k+1)).
  // After seven steps the exponent is 254, which gives the inverse.
  always_comb begin
    acc_d   = gf_mul(acc_q, sq_q);
    sq_d    = gf_mul(sq_q, sq_q);
    sq_init = gf_mul(in_data, in_data);
  end

  // Ready is gated by reset, so it reads 0 while reset is held.
  // It rises as soon as reset releases, allowing acceptance on the first edge.
  assign in_ready  = rst_n & (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= 8'h00;
      sq_q        <= 8'h00;
      cnt_q       <= 3'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sq_q    <= sq_init;
            acc_q   <= 8'h01;
            cnt_q   <= 3'd0;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          sq_q  <= sq_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd6) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= acc_d;
          end
        end
        DONE: begin
          // No new byte is taken on the handshake edge.
          // IDLE is re-entered first, and acceptance happens on a later edge.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
